// File: rtl/sobel_stream_packer.sv
// sobel_stream_packer
//   Buffers the per-pixel Sobel RGB stream in a small show-ahead FIFO and
//   presents it to a back-pressuring sink over valid/ready. Each outgoing
//   pixel is tagged with x/y coordinates and sof/eol/eof flags. frame_done_o
//   pulses for one cycle after the last pixel of a frame is transferred.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   red/green/blue_i   input pixel, sampled when done_i is high
//   done_i             per-pixel valid strobe
//   pix_o/pix_valid_o  FIFO head {r,g,b} and non-empty flag
//   pix_ready_i        sink accept
//   x_o/y_o            coordinates of pix_o
//   sof_o/eol_o/eof_o  frame position flags, qualified by pix_valid_o
//   frame_done_o       one-cycle pulse after the eof transfer
//   fill_o             FIFO occupancy
//   overflow_o         sticky: a pixel was dropped
module sobel_stream_packer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    red_i,
  input  logic [7:0]                    green_i,
  input  logic [7:0]                    blue_i,
  input  logic                          done_i,
  output logic [23:0]                   pix_o,
  output logic                          pix_valid_o,
  input  logic                          pix_ready_i,
  output logic [$clog2(IMG_WIDTH)-1:0]  x_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] y_o,
  output logic                          sof_o,
  output logic                          eol_o,
  output logic                          eof_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          overflow_o
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          fd_q, fd_d;
  logic          ov_q, ov_d;
  logic          xfer, wr, full, eol, last_row;

  always_comb begin
    xfer     = valid_q && pix_ready_i;
    full     = (fill_q == FW'(FIFO_DEPTH));
    // A transfer in the same cycle frees the head slot, so a full FIFO
    // still accepts the write.
    wr       = done_i && (!full || xfer);
    eol      = (x_q == XW'(IMG_WIDTH - 1));
    last_row = (y_q == YW'(IMG_HEIGHT - 1));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    x_d      = x_q;
    y_d      = y_q;

    // Power-of-two depth: pointers wrap naturally.
    if (wr)   wr_ptr_d = wr_ptr_q + AW'(1);
    if (xfer) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr, xfer})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    valid_d = (fill_d != '0);

    if (xfer) begin
      if (eol) begin
        x_d = '0;
        y_d = last_row ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    fd_d = xfer && eol && last_row;
    ov_d = ov_q || (done_i && !wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      fd_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fd_q     <= fd_d;
      ov_q     <= ov_d;
    end
  end

  // Storage carries no reset; visibility is governed by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[wr_ptr_q] <= {red_i, green_i, blue_i};
  end

  // Empty FIFO drives zero rather than stale storage.
  assign pix_o        = valid_q ? mem[rd_ptr_q] : 24'h0;
  assign pix_valid_o  = valid_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign sof_o        = valid_q && (x_q == '0) && (y_q == '0);
  assign eol_o        = valid_q && eol;
  assign eof_o        = valid_q && eol && last_row;
  assign frame_done_o = fd_q;
  assign fill_o       = fill_q;
  assign overflow_o   = ov_q;
endmodule
